// File: rtl/video_pkg.sv
// Shared types and constants for the framebuffer reader: FSM state encoding and
// Wishbone cycle-type tags.
package video_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } rd_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  function automatic logic [31:0] word_to_byte_adr(input logic [31:0] word);
    return {word[29:0], 2'b00};
  endfunction

endpackage

// File: rtl/frame_reader_chk.sv
// Protocol checker for frame_reader: an acknowledged beat must never meet a
// full pixel FIFO, since the burst start rule reserves room for a whole burst.
module frame_reader_chk (
  input logic clk,
  input logic rst_n,
  input logic i_ack,
  input logic i_cyc,
  input logic i_full
);

  a_no_ack_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_cyc && i_ack && i_full));

endmodule

// File: rtl/pixel_fifo.sv
// Synchronous show-ahead FIFO for tagged pixels; the head entry is visible on
// o_rdata whenever the FIFO is not empty, and reads as zero when it is.
module pixel_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_free
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == DEPTH_C);
  assign o_empty = (r_count == (AW + 1)'(0));
  assign o_free  = DEPTH_C - r_count;
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_rdata = o_empty ? WIDTH'(0) : r_mem[r_rptr];

  // storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  // pointers and occupancy; simultaneous push and pop leave the count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= AW'(0);
      r_rptr  <= AW'(0);
      r_count <= (AW + 1)'(0);
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/frame_reader.sv
// Wishbone burst reader that streams a HDISP x VDISP framebuffer in raster order
// into a pixel FIFO. Define FRAME_READER_CTI_EN for incrementing-burst CTI tags.
module frame_reader
  import video_pkg::*;
#(
  parameter int HDISP      = 800,
  parameter int VDISP      = 480,
  parameter int BURST_LEN  = 64,
  parameter int FIFO_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] wshb_adr,
  input  logic [31:0] wshb_dat_sm,
  input  logic        wshb_ack,
  output logic        wshb_cyc,
  output logic        wshb_stb,
  output logic        wshb_we,
  output logic [3:0]  wshb_sel,
  output logic [2:0]  wshb_cti,
  output logic [1:0]  wshb_bte,
  output logic [23:0] pix_data,
  output logic        pix_sof,
  output logic        pix_valid,
  input  logic        pix_ready
);

  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam int BW  = $clog2(BURST_LEN + 1);
  localparam logic [31:0]   HDISP_W    = 32'(HDISP);
  localparam logic [15:0]   LAST_PIX   = 16'(HDISP - 1);
  localparam logic [15:0]   LAST_LINE  = 16'(VDISP - 1);
  localparam logic [BW-1:0] LAST_BEAT  = BW'(BURST_LEN - 1);
  localparam logic [FAW:0]  BURST_FREE = (FAW + 1)'(BURST_LEN);

  rd_state_e     r_state;
  rd_state_e     w_next_state;
  logic [15:0]   r_pix;
  logic [15:0]   r_line;
  logic [BW-1:0] r_beat;
  logic          w_ack;
  logic          w_frame_end;
  logic          w_burst_end;
  logic          w_sof;
  logic [31:0]   w_word;
  logic [2:0]    w_cti;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic [FAW:0]  w_free;
  logic [24:0]   w_fifo_head;
  logic          w_unused;

  assign w_frame_end = (r_pix == LAST_PIX) && (r_line == LAST_LINE);
  assign w_burst_end = (r_beat == LAST_BEAT) || w_frame_end;
  assign w_ack       = (r_state == BURST) && wshb_ack;
  assign w_sof       = (r_pix == 16'd0) && (r_line == 16'd0);
  assign w_word      = HDISP_W * {16'd0, r_line} + {16'd0, r_pix};

  assign wshb_adr  = word_to_byte_adr(w_word);
  assign wshb_cyc  = (r_state == BURST);
  assign wshb_stb  = (r_state == BURST);
  assign wshb_we   = 1'b0;
  assign wshb_sel  = 4'b1111;
  assign wshb_bte  = 2'b00;
  assign wshb_cti  = w_cti;
  assign pix_valid = ~w_fifo_empty;
  assign pix_sof   = w_fifo_head[24];
  assign pix_data  = w_fifo_head[23:0];
  assign w_unused  = &{1'b0, wshb_dat_sm[31:24], w_word[31:30]};

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // a burst starts only with room for a full burst; leaving BURST always costs an IDLE cycle
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_free >= BURST_FREE) begin
          w_next_state = BURST;
        end else begin
          w_next_state = IDLE;
        end
      end
      BURST: begin
        if (w_ack && w_burst_end) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = BURST;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // raster and beat counters advance only on acknowledged beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix  <= 16'd0;
      r_line <= 16'd0;
      r_beat <= BW'(0);
    end else if (w_ack) begin
      r_beat <= w_burst_end ? BW'(0) : r_beat + BW'(1);
      if (r_pix == LAST_PIX) begin
        r_pix  <= 16'd0;
        r_line <= (r_line == LAST_LINE) ? 16'd0 : r_line + 16'd1;
      end else begin
        r_pix <= r_pix + 16'd1;
      end
    end
  end

  // cycle-type tag for the beat currently on the bus
  always_comb begin
    w_cti = CTI_CLASSIC;
`ifdef FRAME_READER_CTI_EN
    if (r_state == BURST) begin
      w_cti = w_burst_end ? CTI_EOB : CTI_INCR;
    end else begin
      w_cti = CTI_CLASSIC;
    end
`else
    w_cti = CTI_CLASSIC;
`endif
  end

  pixel_fifo #(
    .WIDTH (25),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_ack),
    .i_wdata ({w_sof, wshb_dat_sm[23:0]}),
    .i_pop   (pix_valid & pix_ready),
    .o_rdata (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_free  (w_free)
  );

  frame_reader_chk u_chk (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_ack  (wshb_ack),
    .i_cyc  (wshb_cyc),
    .i_full (w_fifo_full)
  );

endmodule

// File: doc/frame_reader.md
FRAME_READER -- requirements
Module: frame_reader

Interface
REQ-001 SHALL have parameter HDISP, default 800, pixels per line.
REQ-002 SHALL have parameter VDISP, default 480, lines per frame.
REQ-003 SHALL have parameter BURST_LEN, default 64, maximum words per Wishbone cycle.
REQ-004 SHALL have parameter FIFO_DEPTH, default 256, pixel FIFO entries (power of two, >= 2*BURST_LEN).
REQ-005 SHALL have ports, one clock and asynchronous active-low reset:
 clk  in  1  single clock, all logic on rising edge
 rst_n  in  1  asynchronous active-low reset
 wshb_adr  out  32  byte address of current read word
 wshb_dat_sm  in  32  read data, pixel in bits [23:0]
 wshb_ack  in  1  slave acknowledge, one word per cycle high
 wshb_cyc  out  1  bus cycle active
 wshb_stb  out  1  strobe
 wshb_we  out  1  constant 0 (read)
 wshb_sel  out  4  constant 4'b1111
 wshb_cti  out  3  cycle type tag
 wshb_bte  out  2  constant 2'b00
 pix_data  out  24  RGB pixel to video controller
 pix_sof  out  1  pix_data is pixel (0,0) of a frame
 pix_valid  out  1  FIFO not empty
 pix_ready  in  1  consumer accepts pixel this cycle

Function
REQ-006 SHALL read the framebuffer in raster order, address = (HDISP*line + pixel)*4, wrapping to 0 after pixel (HDISP-1, VDISP-1).
REQ-007 SHALL implement states IDLE, BURST; IDLE->BURST when FIFO free entries >= BURST_LEN; BURST->IDLE after the last ack of the burst.
REQ-008 SHALL hold wshb_cyc and wshb_stb both high for the whole of BURST, both low in IDLE.
REQ-009 SHALL end a burst after BURST_LEN acks or after the ack of the frame's last pixel, whichever first; a new burst never crosses the frame boundary.
REQ-010 SHALL advance pixel/line counters and push {sof, dat_sm[23:0]} into the FIFO only in cycles where wshb_ack is high.
REQ-011 SHALL update wshb_adr combinationally from the counters, so the next address is presented the cycle after each ack.
REQ-012 SHALL tag sof=1 on the word fetched at address 0 and sof=0 otherwise.
REQ-013 SHALL present FIFO head show-ahead on pix_data/pix_sof with pix_valid = not empty; pop when pix_valid and pix_ready.
REQ-014 SHALL support simultaneous push and pop in one cycle with occupancy unchanged.
REQ-015 SHALL never push when full; the free-space rule of REQ-007 guarantees this, and an ack arriving while full SHALL be dropped (assertion-checked).
REQ-016 SHALL ignore pix_ready when pix_valid is low.
REQ-017 SHALL insert at least one IDLE cycle between consecutive bursts.

Reset
REQ-018 SHALL, on rst_n low, asynchronously clear: state to IDLE, wshb_cyc=0, wshb_stb=0, counters to 0 (wshb_adr=0), FIFO empty (pix_valid=0), pix_data=0, pix_sof=0, wshb_cti=0.
REQ-019 SHALL, on reset mid-burst, drop cyc/stb immediately and restart from address 0 with sof on the first word after rst_n rises.

Configuration
REQ-020 SHALL, with FRAME_READER_CTI_EN defined, drive wshb_cti=3'b010 on every burst beat except the last, 3'b111 on the last beat.
REQ-021 SHALL, without FRAME_READER_CTI_EN, drive wshb_cti=3'b000 constantly (classic cycles), all else identical.

Structure
REQ-022 SHALL place the state enum (IDLE, BURST) and CTI constants (CLASSIC=000, INCR=010, EOB=111) in shared package video_pkg.
REQ-023 SHALL instantiate one sub-module pixel_fifo: synchronous, show-ahead, 25-bit wide, FIFO_DEPTH deep, with full/empty and free-count outputs.

Verification
REQ-024 Reset release, slave acks every cycle, pix_ready=0 -> first burst at adr 0..252, 64 acks, cyc drops, FIFO count 64, pix_sof=1 with first word.
REQ-025 pix_ready=0 held -> bursts stop once free entries < 64: FIFO count exactly 256 after 4 bursts, cyc stays 0.
REQ-026 HDISP=8, VDISP=2, BURST_LEN=4, pix_ready=1 -> adr sequence 0..60 then 0 again; sof set only on words at adr 0; bursts never span adr 60->0.
REQ-027 Slave acks every 3rd cycle, pix_ready toggling -> pix_data sequence equals memory model in raster order, no loss or duplication over 2 frames.
REQ-028 rst_n pulsed low mid-burst at adr 0x1F0 -> cyc/stb low same cycle, pix_valid=0; after release first read at adr 0 with sof=1.
REQ-029 With and without FRAME_READER_CTI_EN -> cti 010...010,111 per burst vs constant 000; data stream identical.
